mul_div_seq: RTL and testbench

- Iterative 32-bit unsigned multiply/divide sequencer built around a single internal ripple-carry add/sub datapath (RC_ADD_SUB_32); the adder is its only arithmetic resource.
- Sits beside the ALU and serves MUL and DIV instructions.
- The control unit stalls on BUSY and samples results on DONE.
- Multiply uses shift-add; divide uses restoring shift-subtract. One bit is resolved per clock.

---
 rtl/mul_div_seq.sv | 153 +++++++++++++++
 tb/tb_mul_div_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_seq.sv
// mul_div_seq: iterative 32-bit unsigned multiply (shift-add) / divide (restoring)
// sequencer sharing one ripple-carry add/sub datapath; one result bit per clock.  Rev 1.0
`default_nettype none

module rc_add_sub_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sna,
    output logic [31:0] sum,
    output logic        co
);
    logic [31:0] bx;
    logic        carry;

    // sna=1 turns the adder into a - b via invert-and-carry-in; co=1 then means no borrow
    always_comb begin
        bx    = b ^ {32{sna}};
        carry = sna;
        sum   = '0;
        for (int i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ bx[i] ^ carry;
            carry  = (a[i] & bx[i]) | (carry & (a[i] ^ bx[i]));
        end
        co = carry;
    end
endmodule

module mul_div_seq #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        dz
);
    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            op_q;
    logic [31:0]     b_q;
    logic [CW-1:0]   cnt;

    logic            div0;
    logic            t;
    logic [31:0]     rem_sh;
    logic [31:0]     add_a, add_b, sum;
    logic            co;
    logic            div_ok;

    assign div0   = op & (b == 32'd0);
    assign t      = hi[31];
    assign rem_sh = {hi[30:0], lo[31]};
    assign add_a  = op_q ? rem_sh : hi;
    assign add_b  = op_q ? b_q : (lo[0] ? b_q : 32'd0);
    assign div_ok = t | co;

    rc_add_sub_32 u_add (
        .a   (add_a),
        .b   (add_b),
        .sna (op_q),
        .sum (sum),
        .co  (co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_nxt = S_FIN;
            end
            S_FIN: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Divide-by-zero enters RUN on its final count with the datapath frozen,
    // so its result appears one edge after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi   <= '0;
            lo   <= '0;
            dz   <= 1'b0;
            op_q <= 1'b0;
            b_q  <= '0;
            cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q <= op;
                        b_q  <= b;
                        if (div0) begin
                            hi  <= a;
                            lo  <= '1;
                            dz  <= 1'b1;
                            cnt <= LAST;
                        end else begin
                            hi  <= '0;
                            lo  <= a;
                            dz  <= 1'b0;
                            cnt <= '0;
                        end
                    end
                end
                S_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (!dz) begin
                        if (!op_q) begin
                            hi <= {co, sum[31:1]};
                            lo <= {sum[0], lo[31:1]};
                        end else if (div_ok) begin
                            hi <= sum;
                            lo <= {lo[30:0], 1'b1};
                        end else begin
                            hi <= rem_sh;
                            lo <= {lo[30:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_mul_div_seq.sv
// tb_mul_div_seq: directed table, hand-written handshake/reset sequences and
// randomized operations compared against an arithmetic reference model.
`default_nettype none

module tb_mul_div_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        op_i;
    logic [31:0] a_i, b_i;
    logic [31:0] hi, lo;
    logic        busy, done, dz;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t tbl[6];

    mul_div_seq #(.ITER(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op_i),
        .a     (a_i),
        .b     (b_i),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: {dz, hi, lo} from plain arithmetic
    function automatic logic [64:0] model(input logic op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        if (!op) begin
            p = 64'(a) * 64'(b);
            return {1'b0, p};
        end else if (b == 32'd0) begin
            return {1'b1, a, 32'hFFFF_FFFF};
        end else begin
            return {1'b0, a % b, a / b};
        end
    endfunction

    function automatic int latency(input logic op, input logic [31:0] b);
        return (op && b == 32'd0) ? 1 : 32;
    endfunction

    // Called #1 after a rising edge; returns #1 after the accepting edge
    task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
        op_i  = op;
        a_i   = a;
        b_i   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_i  = 1'($urandom);
        a_i   = $urandom;
        b_i   = $urandom;
        check("busy_after_accept", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_done(input logic [31:0] eh, input logic [31:0] el, input logic edz,
                             input int lat, input bit tail);
        int n = 0;
        bit got = 0;
        while (n < 40 && !got) begin
            @(posedge clk);
            #1;
            n++;
            if (done) got = 1;
        end
        check("latency", 64'(n), 64'(lat));
        check("hi", {32'd0, hi}, {32'd0, eh});
        check("lo", {32'd0, lo}, {32'd0, el});
        check("dz", {63'd0, dz}, {63'd0, edz});
        if (tail) begin
            @(posedge clk);
            #1;
            check("done_pulse_one_cycle", {63'd0, done}, 64'd0);
            check("idle_not_busy", {63'd0, busy}, 64'd0);
            check("hold_in_idle", {dz, hi, lo}, {edz, eh, el});
        end
    endtask

    initial begin
        logic        rop;
        logic [31:0] ra, rb;
        logic [64:0] m;
        bit          seen;

        tbl[0] = '{op: 1'b0, a: 32'd7,          b: 32'd9,          hi: 32'd0,          lo: 32'd63,         dz: 1'b0};
        tbl[1] = '{op: 1'b0, a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  hi: 32'hFFFF_FFFE,  lo: 32'h0000_0001,  dz: 1'b0};
        tbl[2] = '{op: 1'b1, a: 32'd100,        b: 32'd7,          hi: 32'd2,          lo: 32'd14,         dz: 1'b0};
        tbl[3] = '{op: 1'b1, a: 32'hFFFF_FFFF,  b: 32'h8000_0000,  hi: 32'h7FFF_FFFF,  lo: 32'd1,          dz: 1'b0};
        tbl[4] = '{op: 1'b1, a: 32'd123,        b: 32'd0,          hi: 32'd123,        lo: 32'hFFFF_FFFF,  dz: 1'b1};
        tbl[5] = '{op: 1'b0, a: 32'd3,          b: 32'd4,          hi: 32'd0,          lo: 32'd12,         dz: 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        op_i  = 1'b0;
        a_i   = '0;
        b_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {hi, lo}, 64'd0);
        check("reset_flags", {61'd0, busy, done, dz}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b);
            wait_done(tbl[i].hi, tbl[i].lo, tbl[i].dz, latency(tbl[i].op, tbl[i].b), 1'b1);
        end

        // START during RUN must not disturb the running 7*9
        issue(1'b0, 32'd7, 32'd9);
        repeat (5) @(posedge clk);
        #1;
        op_i  = 1'b0;
        a_i   = 32'd5;
        b_i   = 32'd5;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(32'd0, 32'd63, 1'b0, 24, 1'b1);

        // Back-to-back: START held through FIN is ignored there, accepted in the next IDLE
        issue(1'b0, 32'd6, 32'd7);
        wait_done(32'd0, 32'd42, 1'b0, 32, 1'b0);
        op_i  = 1'b1;
        a_i   = 32'd8;
        b_i   = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("fin_start_ignored", {62'd0, busy, done}, 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_accepted", {63'd0, busy}, 64'd1);
        wait_done(32'd2, 32'd2, 1'b0, 32, 1'b1);

        for (int k = 0; k < 24; k++) begin
            rop = 1'($urandom);
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(0, 15));
                1:       rb = ra >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            m = model(rop, ra, rb);
            issue(rop, ra, rb);
            wait_done(m[63:32], m[31:0], m[64], latency(rop, rb), 1'b1);
        end

        // Asynchronous reset mid-RUN aborts without a DONE
        issue(1'b0, 32'd7, 32'd9);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_data", {hi, lo}, 64'd0);
        check("async_reset_flags", {61'd0, busy, done, dz}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        check("no_spurious_done", {63'd0, seen}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

`default_nettype wire
